// File: rtl/rom_ram_xfer_ctrl_pkg.sv
// Shared types and constants for the ROM-to-RAM transfer controller.
package rom_ram_xfer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_FILL  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic MODE_COPY   = 1'b0;
    localparam logic MODE_FILL   = 1'b1;
    localparam int   ROM_LAT_MAX = 4;

endpackage

// File: rtl/rom_ram_xfer_ctrl_if.sv
// Sequencer/memory-facing signal bundle of the transfer controller.
interface rom_ram_xfer_ctrl_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] src_base;
    logic [ADDR_W-1:0] dst_base;
    logic [ADDR_W:0]   len;
    logic [DATA_W-1:0] fill_val;
    logic              abort;
    logic [DATA_W-1:0] rom_data;
    logic              read_rom;
    logic [ADDR_W-1:0] rom_addr;
    logic              write_ram;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              busy;
    logic              done;

    modport master (
        output start, mode, src_base, dst_base, len, fill_val, abort, rom_data,
        input  read_rom, rom_addr, write_ram, ram_addr, ram_data, busy, done
    );

    modport slave (
        input  start, mode, src_base, dst_base, len, fill_val, abort, rom_data,
        output read_rom, rom_addr, write_ram, ram_addr, ram_data, busy, done
    );
endinterface

// File: rtl/rom_ram_xfer_ctrl_lat_pipe.sv
// ROM_LAT-stage valid + destination-address shift register matching ROM read latency.
module xfer_lat_pipe #(
    parameter int ADDR_W  = 3,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    input  logic [ADDR_W-1:0] in_addr_i,
    output logic              out_valid_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic              any_valid_o
);
    logic [ROM_LAT-1:0]        vld_q, vld_d;
    logic [ROM_LAT*ADDR_W-1:0] addr_q, addr_d;

    generate
        if (ROM_LAT == 1) begin : g_single
            assign vld_d  = in_valid_i;
            assign addr_d = in_addr_i;
        end else begin : g_multi
            assign vld_d  = {vld_q[ROM_LAT-2:0], in_valid_i};
            assign addr_d = {addr_q[(ROM_LAT-1)*ADDR_W-1:0], in_addr_i};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            addr_q <= '0;
        end else begin
            vld_q  <= flush_i ? '0 : vld_d;
            addr_q <= addr_d;
        end
    end

    assign out_valid_o = vld_q[ROM_LAT-1];
    assign out_addr_o  = addr_q[ROM_LAT*ADDR_W-1 -: ADDR_W];
    assign any_valid_o = |vld_q;
endmodule

// File: rtl/rom_ram_xfer_ctrl.sv
// Copies a block of words ROM->RAM, or fills a RAM block with a constant.
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_RUN   | issuing ROM reads (copy)
//   ST_DRAIN | reads done, waiting for in-flight writes
//   ST_FILL  | writing fill constant
//   ST_DONE  | one-cycle done pulse
module rom_ram_xfer_ctrl
    import rom_ram_xfer_pkg::*;
#(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 8,
    parameter int ROM_LAT = 1
) (
    input logic               clk,
    input logic               rst_n,
    rom_ram_xfer_ctrl_if.slave bus
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_cnt_q, src_cnt_d;
    logic [ADDR_W-1:0] dst_cnt_q, dst_cnt_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic              read_rom_q, read_rom_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              write_ram_q, write_ram_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              flush;
    logic              pipe_out_valid, pipe_any_valid;
    logic [ADDR_W-1:0] pipe_out_addr;

    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   L_ONE = (ADDR_W+1)'(1);

    // Each issued read carries its destination address down the latency pipe.
    xfer_lat_pipe #(.ADDR_W(ADDR_W), .ROM_LAT(ROM_LAT)) u_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush),
        .in_valid_i (read_rom_q),
        .in_addr_i  (dst_cnt_q),
        .out_valid_o(pipe_out_valid),
        .out_addr_o (pipe_out_addr),
        .any_valid_o(pipe_any_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            src_cnt_q   <= '0;
            dst_cnt_q   <= '0;
            rem_q       <= '0;
            fill_q      <= '0;
            read_rom_q  <= 1'b0;
            rom_addr_q  <= '0;
            write_ram_q <= 1'b0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_cnt_q   <= src_cnt_d;
            dst_cnt_q   <= dst_cnt_d;
            rem_q       <= rem_d;
            fill_q      <= fill_d;
            read_rom_q  <= read_rom_d;
            rom_addr_q  <= rom_addr_d;
            write_ram_q <= write_ram_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        src_cnt_d   = src_cnt_q;
        dst_cnt_d   = dst_cnt_q;
        rem_d       = rem_q;
        fill_d      = fill_q;
        read_rom_d  = 1'b0;
        rom_addr_d  = rom_addr_q;
        write_ram_d = pipe_out_valid;
        ram_addr_d  = pipe_out_valid ? pipe_out_addr : ram_addr_q;
        ram_data_d  = pipe_out_valid ? bus.rom_data  : ram_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        flush       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.len == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        rem_d  = bus.len - L_ONE;
                        fill_d = bus.fill_val;
                        busy_d = 1'b1;
                        if (bus.mode == MODE_FILL) begin
                            state_d     = ST_FILL;
                            write_ram_d = 1'b1;
                            ram_addr_d  = bus.dst_base;
                            ram_data_d  = bus.fill_val;
                            dst_cnt_d   = bus.dst_base + A_ONE;
                        end else begin
                            state_d    = ST_RUN;
                            read_rom_d = 1'b1;
                            rom_addr_d = bus.src_base;
                            src_cnt_d  = bus.src_base + A_ONE;
                            dst_cnt_d  = bus.dst_base;
                        end
                    end
                end
            end
            ST_RUN: begin
                if (read_rom_q) dst_cnt_d = dst_cnt_q + A_ONE;
                if (rem_q != '0) begin
                    read_rom_d = 1'b1;
                    rom_addr_d = src_cnt_q;
                    src_cnt_d  = src_cnt_q + A_ONE;
                    rem_d      = rem_q - L_ONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Pipe empty means the write now on the bus is the last one.
                if (!pipe_any_valid) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            ST_FILL: begin
                if (rem_q != '0) begin
                    write_ram_d = 1'b1;
                    ram_addr_d  = dst_cnt_q;
                    ram_data_d  = fill_q;
                    dst_cnt_d   = dst_cnt_q + A_ONE;
                    rem_d       = rem_q - L_ONE;
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (bus.abort && (state_q == ST_RUN || state_q == ST_DRAIN || state_q == ST_FILL)) begin
            state_d     = ST_IDLE;
            read_rom_d  = 1'b0;
            write_ram_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            flush       = 1'b1;
        end
    end

    assign bus.read_rom  = read_rom_q;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.write_ram = write_ram_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_data  = ram_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_rom_ram_xfer_ctrl.sv
// Directed table-driven bench for rom_ram_xfer_ctrl at ROM latencies 1, 2 and 3.
module tb_rom_ram_xfer_ctrl;
    import rom_ram_xfer_pkg::*;

    typedef struct {
        int         sel;          // instance = ROM latency (1..3)
        logic       mode;
        logic [2:0] src;
        logic [2:0] dst;
        logic [3:0] len;
        logic [7:0] fill;
        int         abort_cyc;    // -1 none
        int         cut;          // cycle after which strobes must be gone, 0 none
        int         restart_cyc;  // extra start pulse while busy, 0 none
        int         first_wr;
        int         busy_last;
        int         done_cyc;     // 0 none
        int         ncyc;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       start_r, mode_r, abort_r;
    logic [2:0] src_r, dst_r;
    logic [3:0] len_r;
    logic [7:0] fill_r;
    int         sel_r;
    int         n_chk = 0;
    int         n_pass = 0;
    vec_t       vecs[13];

    rom_ram_xfer_ctrl_if #(.ADDR_W(3), .DATA_W(8)) b1();
    rom_ram_xfer_ctrl_if #(.ADDR_W(3), .DATA_W(8)) b2();
    rom_ram_xfer_ctrl_if #(.ADDR_W(3), .DATA_W(8)) b3();

    assign b1.start = start_r && (sel_r == 1);
    assign b2.start = start_r && (sel_r == 2);
    assign b3.start = start_r && (sel_r == 3);
    assign b1.mode = mode_r;     assign b2.mode = mode_r;     assign b3.mode = mode_r;
    assign b1.src_base = src_r;  assign b2.src_base = src_r;  assign b3.src_base = src_r;
    assign b1.dst_base = dst_r;  assign b2.dst_base = dst_r;  assign b3.dst_base = dst_r;
    assign b1.len = len_r;       assign b2.len = len_r;       assign b3.len = len_r;
    assign b1.fill_val = fill_r; assign b2.fill_val = fill_r; assign b3.fill_val = fill_r;
    assign b1.abort = abort_r;   assign b2.abort = abort_r;   assign b3.abort = abort_r;

    rom_ram_xfer_ctrl #(.ADDR_W(3), .DATA_W(8), .ROM_LAT(1)) u_lat1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    rom_ram_xfer_ctrl #(.ADDR_W(3), .DATA_W(8), .ROM_LAT(2)) u_lat2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    rom_ram_xfer_ctrl #(.ADDR_W(3), .DATA_W(8), .ROM_LAT(3)) u_lat3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    function automatic logic [7:0] rom_fn(input logic [2:0] a);
        return {a, ~a, 2'b10};
    endfunction

    // ROM models: data for a read appears exactly ROM_LAT cycles later, junk otherwise.
    logic [7:0] p1;
    logic [7:0] p2 [2];
    logic [7:0] p3 [3];
    always @(posedge clk) begin
        p1    <= b1.read_rom ? rom_fn(b1.rom_addr) : 8'hEE;
        p2[0] <= b2.read_rom ? rom_fn(b2.rom_addr) : 8'hEE;
        p2[1] <= p2[0];
        p3[0] <= b3.read_rom ? rom_fn(b3.rom_addr) : 8'hEE;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign b1.rom_data = p1;
    assign b2.rom_data = p2[1];
    assign b3.rom_data = p3[2];

    function automatic logic [17:0] obs_of(input int s);
        case (s)
            1: return {b1.read_rom, b1.rom_addr, b1.write_ram, b1.ram_addr, b1.ram_data, b1.busy, b1.done};
            2: return {b2.read_rom, b2.rom_addr, b2.write_ram, b2.ram_addr, b2.ram_data, b2.busy, b2.done};
            default: return {b3.read_rom, b3.rom_addr, b3.write_ram, b3.ram_addr, b3.ram_data, b3.busy, b3.done};
        endcase
    endfunction

    task automatic chk(input string name, input int c, input logic [17:0] act, input logic [17:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc %0d: got %05h want %05h", name, c, act, exp);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        logic        erd, ewr, ebusy, edone;
        logic [2:0]  era, ewa;
        logic [7:0]  ewd;
        logic [17:0] act, exp;
        int          i;
        @(negedge clk);
        sel_r = v.sel; mode_r = v.mode; src_r = v.src; dst_r = v.dst;
        len_r = v.len; fill_r = v.fill; start_r = 1'b1;
        abort_r = (v.abort_cyc == 0);
        for (int c = 1; c <= v.ncyc; c++) begin
            @(negedge clk);
            start_r = 1'b0;
            abort_r = (v.abort_cyc == c);
            if (c == v.restart_cyc || c == v.done_cyc) begin
                mode_r = ~v.mode; src_r = v.src ^ 3'd5; dst_r = v.dst ^ 3'd2;
                len_r = 4'd3; fill_r = ~v.fill; start_r = 1'b1;
            end
            i     = c - v.first_wr;
            erd   = (v.mode == MODE_COPY) && (c <= int'(v.len)) && (v.cut == 0 || c <= v.cut);
            ewr   = (c >= v.first_wr) && (c < v.first_wr + int'(v.len)) && (v.cut == 0 || c <= v.cut);
            era   = erd ? 3'(int'(v.src) + c - 1) : 3'd0;
            ewa   = ewr ? 3'(int'(v.dst) + i) : 3'd0;
            ewd   = !ewr ? 8'd0 : ((v.mode == MODE_FILL) ? v.fill : rom_fn(3'(int'(v.src) + i)));
            ebusy = (c <= v.busy_last);
            edone = (c == v.done_cyc);
            exp   = {erd, era, ewr, ewa, ewd, ebusy, edone};
            act   = obs_of(v.sel);
            act   = {act[17], erd ? act[16:14] : 3'd0, act[13], ewr ? act[12:10] : 3'd0,
                     ewr ? act[9:2] : 8'd0, act[1:0]};
            chk(name, c, act, exp);
        end
        start_r = 1'b0;
        abort_r = 1'b0;
    endtask

    initial begin
        logic [17:0] o;
        //          sel mode       src   dst   len   fill   abrt cut rst fwr bsy done ncyc
        vecs[0]  = '{1, MODE_COPY, 3'd2, 3'd5, 4'd4, 8'h00, -1,  0,  0,  3,  6,  7,   9};
        vecs[1]  = '{1, MODE_FILL, 3'd0, 3'd6, 4'd3, 8'hA5, -1,  0,  0,  1,  3,  4,   6};
        vecs[2]  = '{1, MODE_COPY, 3'd3, 3'd3, 4'd0, 8'h00, -1,  0,  0,  1,  0,  1,   3};
        vecs[3]  = '{3, MODE_COPY, 3'd1, 3'd2, 4'd8, 8'h00, -1,  0,  4,  5, 12, 13,  15};
        vecs[4]  = '{2, MODE_COPY, 3'd0, 3'd0, 4'd1, 8'h00, -1,  0,  0,  4,  4,  5,   7};
        vecs[5]  = '{2, MODE_FILL, 3'd0, 3'd3, 4'd8, 8'h3C, -1,  0,  0,  1,  8,  9,  11};
        vecs[6]  = '{3, MODE_FILL, 3'd0, 3'd4, 4'd0, 8'h77, -1,  0,  0,  1,  0,  1,   3};
        vecs[7]  = '{2, MODE_COPY, 3'd3, 3'd4, 4'd6, 8'h00,  3,  3,  0,  4,  3,  0,  10};
        vecs[8]  = '{2, MODE_COPY, 3'd0, 3'd7, 4'd2, 8'h00, -1,  0,  0,  4,  5,  6,   8};
        vecs[9]  = '{1, MODE_FILL, 3'd0, 3'd1, 4'd5, 8'hC3,  2,  2,  0,  1,  2,  0,   6};
        vecs[10] = '{3, MODE_COPY, 3'd6, 3'd0, 4'd2, 8'h00,  4,  4,  0,  5,  4,  0,   9};
        vecs[11] = '{1, MODE_FILL, 3'd0, 3'd2, 4'd2, 8'h5E,  3,  0,  0,  1,  2,  3,   5};
        vecs[12] = '{1, MODE_COPY, 3'd4, 3'd4, 4'd3, 8'h00,  0,  0,  0,  3,  5,  6,   8};

        rst_n = 1'b0; start_r = 1'b0; abort_r = 1'b0; sel_r = 1;
        mode_r = 1'b0; src_r = '0; dst_r = '0; len_r = '0; fill_r = '0;
        repeat (2) @(negedge clk);
        chk("reset_lat1", 0, obs_of(1), 18'd0);
        chk("reset_lat2", 0, obs_of(2), 18'd0);
        chk("reset_lat3", 0, obs_of(3), 18'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 13; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

        // Reset asserted in cycle 2 of a copy.
        @(negedge clk);
        sel_r = 1; mode_r = MODE_COPY; src_r = 3'd2; dst_r = 3'd5; len_r = 4'd4; start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        @(negedge clk);
        o = obs_of(1);
        chk("rst_pre", 2, {11'd0, o[17:13], o[1:0]}, {11'd0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0});
        rst_n = 1'b0;
        #1;
        chk("rst_async", 2, obs_of(1), 18'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("rst_idle", c, obs_of(1), 18'd0);
        end
        run_vec(vecs[0], "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rom_ram_xfer_ctrl.md
Name: rom_ram_xfer_ctrl

Overview:
- Parametrised ROM-to-RAM transfer controller: copies a programmable block of words from ROM to RAM, or fills a RAM block with a constant.
- Successor to the fixed 3-bit, fixed-sequence ROM/RAM control unit. Adds configurable width and depth, source and destination bases, length, ROM read latency, fill mode, abort, and a busy/done handshake.
- Sits between the top-level sequencer (start/done) and the ROM and RAM macros.

Parameters:
- ADDR_W, 3, width of ROM and RAM addresses; addresses wrap modulo 2^ADDR_W.
- DATA_W, 8, ROM/RAM word width.
- ROM_LAT, 1, ROM read latency in cycles (1..4). rom_data is valid ROM_LAT cycles after the read_rom cycle.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- mode  in  1  0 = copy ROM to RAM, 1 = fill RAM with fill_val; sampled with start.
- src_base  in  ADDR_W  first ROM address; sampled with start.
- dst_base  in  ADDR_W  first RAM address; sampled with start.
- len  in  ADDR_W+1  word count, 0..2^ADDR_W; sampled with start.
- fill_val  in  DATA_W  fill constant; sampled with start.
- abort  in  1  cancel the transfer in progress.
- rom_data  in  DATA_W  ROM read data.
- read_rom  out  1  ROM read strobe.
- rom_addr  out  ADDR_W  ROM address.
- write_ram  out  1  RAM write strobe.
- ram_addr  out  ADDR_W  RAM address.
- ram_data  out  DATA_W  RAM write data.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- All outputs are registered.
- Reset values: read_rom=0, write_ram=0, rom_addr=0, ram_addr=0, ram_data=0, busy=0, done=0. State=IDLE. Pipeline valid bits cleared.
- States: IDLE, RUN, DRAIN, FILL, DONE.
- IDLE:
  - start=1 and len=0: go to DONE. No memory access; done pulses in cycle 1.
  - start=1, mode=0: latch all inputs, go to RUN.
  - start=1, mode=1: latch all inputs, go to FILL.
- Cycle numbering: cycle 1 is the cycle after the edge at which start is sampled.
- RUN (copy mode):
  - read_rom=1 in cycles 1..len; rom_addr = src_base+i mod 2^ADDR_W for read i.
  - After the last read, go to DRAIN.
- Write pipeline: a ROM_LAT-deep shift register carries valid plus destination address. rom_data is captured at the end of cycle k+ROM_LAT for a read in cycle k. In cycle k+ROM_LAT+1: write_ram=1, ram_addr=dst_base+i, ram_data=captured word.
- DRAIN: stays until the pipeline is empty and the last write has been issued, then goes to DONE.
  - Copy timing: writes in cycles ROM_LAT+2 .. len+ROM_LAT+1; done in cycle len+ROM_LAT+2.
- FILL (fill mode):
  - write_ram=1 in cycles 1..len; ram_addr = dst_base+i; ram_data = fill_val; read_rom stays 0.
  - done in cycle len+1.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. A start sampled in DONE is ignored.
- busy=1 from cycle 1 through the last write cycle inclusive; busy=0 in the done cycle.
- start while busy: ignored; the latched parameters are unchanged.
- abort=1 in RUN, DRAIN or FILL:
  - From the next cycle, read_rom=0 and write_ram=0, and the in-flight pipeline entries are discarded (never written).
  - The block returns to IDLE with busy=0. done does not pulse.
  - abort in IDLE or DONE has no effect.
- Address wrap: base+i wraps silently. len=2^ADDR_W touches every address exactly once.
- Reset mid-transfer: strobes drop immediately, asynchronously; no partial write after reset deassertion.
- Address counters are ADDR_W wide. The remaining-word counter is ADDR_W+1 wide.

Decomposition:
- Shared package rom_ram_xfer_pkg holds:
  - state enum (IDLE, RUN, DRAIN, FILL, DONE);
  - mode constants MODE_COPY=0, MODE_FILL=1;
  - ROM_LAT_MAX=4.
- One sub-module: xfer_lat_pipe, a ROM_LAT-stage valid-plus-address shift register with a synchronous flush input driven by abort.

Test Plan:
- ADDR_W=3, ROM_LAT=1, copy, src=2, dst=5, len=4 -> read_rom cycles 1-4 at addresses 2,3,4,5; write_ram cycles 3-6 at addresses 5,6,7,0 with ROM contents; done in cycle 7; busy in cycles 1-6.
- Fill, dst=6, len=3, fill_val=8'hA5 -> write_ram cycles 1-3 at addresses 6,7,0 with data A5; read_rom never asserted; done in cycle 4.
- len=0 -> no strobes; done in cycle 1; busy stays 0.
- Copy with len=8, ROM_LAT=3; start re-pulsed in cycle 4 with different bases -> exactly 8 reads and 8 writes from the original bases; done in cycle 13.
- Copy with len=6, ROM_LAT=2, abort in cycle 3 -> reads only in cycles 1-3, no writes after cycle 3, no done pulse, busy=0 from cycle 4; a new start is then accepted normally.
- rst_n low in cycle 2 of a copy -> all outputs 0 immediately; after release, idle until the next start.
